// File: rtl/mem_multiport_pkg.sv
// mem_multiport_pkg: shared sizing helpers for the multi-port register file.
package mem_multiport_pkg;

   function automatic int lanes(input int width);
      return width / 8;
   endfunction

   function automatic int addr_bits(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: priority merge of all write ports onto one address, per byte lane.
module mem_lane_merge
   import mem_multiport_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int WRITE_PORTS = 2,
   parameter int AW          = 5
) (
   input  logic [AW-1:0]                               addr,
   input  logic [WRITE_PORTS-1:0]                      we,
   input  logic [WRITE_PORTS-1:0][AW-1:0]              waddr,
   input  logic [WRITE_PORTS-1:0][lanes(WIDTH)-1:0]    wstrb,
   input  logic [WRITE_PORTS-1:0][WIDTH-1:0]           wdata,
   output logic [lanes(WIDTH)-1:0]                     hit,
   output logic [WIDTH-1:0]                            data,
   output logic                                        collide
);
   localparam int L = lanes(WIDTH);

   // Ascending scan: a later (higher-index) port overwrites, so it wins the lane.
   always_comb begin
      hit     = '0;
      data    = '0;
      collide = 1'b0;
      for (int p = 0; p < WRITE_PORTS; p++)
         for (int l = 0; l < L; l++)
            if (we[p] && waddr[p] == addr && wstrb[p][l]) begin
               collide          = collide | hit[l];
               hit[l]           = 1'b1;
               data[8*l +: 8]   = wdata[p][8*l +: 8];
            end
   end

endmodule

// File: rtl/mem_multiport.sv
// mem_multiport: multi-write/multi-read register file with byte strobes,
// lane-written tracking, optional bypass and 0/1-cycle read latency.
module mem_multiport
   import mem_multiport_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 32,
   parameter int READ_PORTS   = 2,
   parameter int WRITE_PORTS  = 2,
   parameter int READ_LATENCY = 0,
   parameter int BYPASS_EN    = 0
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic [READ_PORTS-1:0]                          re,
   input  logic [READ_PORTS-1:0][addr_bits(DEPTH)-1:0]    raddr,
   output logic [READ_PORTS-1:0][WIDTH-1:0]               rdata,
   output logic [READ_PORTS-1:0]                          rvalid,
   output logic [READ_PORTS-1:0]                          runinit,
   input  logic [WRITE_PORTS-1:0]                         we,
   input  logic [WRITE_PORTS-1:0][addr_bits(DEPTH)-1:0]   waddr,
   input  logic [WRITE_PORTS-1:0][lanes(WIDTH)-1:0]       wstrb,
   input  logic [WRITE_PORTS-1:0][WIDTH-1:0]              wdata,
   output logic                                           wcollide
);
   localparam int L  = lanes(WIDTH);
   localparam int AW = addr_bits(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0]      mem, wdat;
   logic [DEPTH-1:0][L-1:0]          lw, whit;
   logic [DEPTH-1:0]                 wcol;
   logic [READ_PORTS-1:0][L-1:0]     bhit;
   logic [READ_PORTS-1:0][WIDTH-1:0] bdat;
   logic [READ_PORTS-1:0][WIDTH-1:0] pre_data;
   logic [READ_PORTS-1:0]            pre_v, pre_u;

   // Only in-range entries get a merger, so out-of-range writes vanish naturally.
   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      mem_lane_merge #(.WIDTH(WIDTH), .WRITE_PORTS(WRITE_PORTS), .AW(AW)) u_merge (
         .addr(AW'(e)), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
         .hit(whit[e]), .data(wdat[e]), .collide(wcol[e])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem      <= '0;
         lw       <= '0;
         wcollide <= 1'b0;
      end else begin
         for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < L; l++)
               if (whit[e][l]) begin
                  mem[e][8*l +: 8] <= wdat[e][8*l +: 8];
                  lw[e][l]         <= 1'b1;
               end
         wcollide <= |wcol;
      end
   end

   if (BYPASS_EN != 0) begin : g_byp
      for (genvar r = 0; r < READ_PORTS; r++) begin : g_port
         mem_lane_merge #(.WIDTH(WIDTH), .WRITE_PORTS(WRITE_PORTS), .AW(AW)) u_merge (
            .addr(raddr[r]), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
            .hit(bhit[r]), .data(bdat[r]), .collide()
         );
      end
   end else begin : g_nobyp
      assign bhit = '0;
      assign bdat = '0;
   end

   always_comb begin
      logic [WIDTH-1:0] ent;
      logic [L-1:0]     wr;
      pre_data = '0;
      pre_v    = '0;
      pre_u    = '0;
      ent      = '0;
      wr       = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         ent = '0;
         wr  = '0;
         if ({1'b0, raddr[r]} < (AW+1)'(DEPTH)) begin
            ent = mem[raddr[r]];
            wr  = lw[raddr[r]];
            for (int l = 0; l < L; l++)
               if (bhit[r][l]) begin
                  ent[8*l +: 8] = bdat[r][8*l +: 8];
                  wr[l]         = 1'b1;
               end
         end
         pre_data[r] = re[r] ? ent : '0;
         pre_v[r]    = re[r];
         pre_u[r]    = re[r] && !(&wr);
      end
   end

   if (READ_LATENCY == 1) begin : g_reg
      always_ff @(posedge clock) begin
         if (reset) begin
            rdata   <= '0;
            rvalid  <= '0;
            runinit <= '0;
         end else begin
            rdata   <= pre_data;
            rvalid  <= pre_v;
            runinit <= pre_u;
         end
      end
   end else begin : g_comb
      assign rdata   = pre_data;
      assign rvalid  = pre_v;
      assign runinit = pre_u;
   end

endmodule

// File: tb/tb_mem_multiport.sv
// tb_mem_multiport: four configurations on shared stimulus, checked against a
// byte-level behavioural model (directed steps, then random traffic).
module tb_mem_multiport;
   logic clock = 1'b0;
   logic reset;
   logic [1:0]        re, we;
   logic [1:0][4:0]   raddr, waddr;
   logic [1:0][3:0]   wstrb;
   logic [1:0][31:0]  wdata;

   logic [1:0][31:0]  rd [4];
   logic [1:0]        rv [4];
   logic [1:0]        ru [4];
   logic              wc [4];

   int errors = 0;
   int checks = 0;

   // 0: plain, 1: bypass, 2: registered, 3: 24 entries + bypass + registered
   mem_multiport #(.BYPASS_EN(0), .READ_LATENCY(0)) dut0 (
      .clock(clock), .reset(reset), .re(re), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]),
      .runinit(ru[0]), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wc[0]));
   mem_multiport #(.BYPASS_EN(1), .READ_LATENCY(0)) dut1 (
      .clock(clock), .reset(reset), .re(re), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]),
      .runinit(ru[1]), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wc[1]));
   mem_multiport #(.BYPASS_EN(0), .READ_LATENCY(1)) dut2 (
      .clock(clock), .reset(reset), .re(re), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]),
      .runinit(ru[2]), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wc[2]));
   mem_multiport #(.DEPTH(24), .BYPASS_EN(1), .READ_LATENCY(1)) dut3 (
      .clock(clock), .reset(reset), .re(re), .raddr(raddr), .rdata(rd[3]), .rvalid(rv[3]),
      .runinit(ru[3]), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .wcollide(wc[3]));

   always #5 clock = ~clock;

   logic [31:0] mmem [32];
   logic [3:0]  mlw  [32];
   logic [33:0] e2q [2], e3q [2], e2n [2], e3n [2];
   logic        cq32, cq24, cn32, cn24;

   function automatic logic [33:0] mread(input int r, input bit byp, input int depth);
      logic [31:0] d;
      logic [3:0]  w;
      int a;
      if (!re[r]) return '0;
      a = int'(raddr[r]);
      if (a >= depth) return {32'h0, 2'b11};
      d = mmem[a];
      w = mlw[a];
      if (byp)
         for (int p = 0; p < 2; p++)
            if (we[p] && int'(waddr[p]) == a)
               for (int l = 0; l < 4; l++)
                  if (wstrb[p][l]) begin
                     d[8*l +: 8] = wdata[p][8*l +: 8];
                     w[l] = 1'b1;
                  end
      return {d, 1'b1, w != 4'hF};
   endfunction

   function automatic logic mcoll(input int depth);
      return we[0] && we[1] && waddr[0] == waddr[1] && int'(waddr[0]) < depth
             && (wstrb[0] & wstrb[1]) != 4'h0;
   endfunction

   task automatic mclear();
      for (int a = 0; a < 32; a++) begin
         mmem[a] = '0;
         mlw[a]  = '0;
      end
      for (int r = 0; r < 2; r++) begin
         e2q[r] = '0;
         e3q[r] = '0;
      end
      cq32 = 1'b0;
      cq24 = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      #1;
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("plain_p%0d", r), {rd[0][r], rv[0][r], ru[0][r]}, mread(r, 0, 32));
         chk($sformatf("bypass_p%0d", r), {rd[1][r], rv[1][r], ru[1][r]}, mread(r, 1, 32));
         chk($sformatf("reg_p%0d", r), {rd[2][r], rv[2][r], ru[2][r]}, e2q[r]);
         chk($sformatf("reg24_p%0d", r), {rd[3][r], rv[3][r], ru[3][r]}, e3q[r]);
         e2n[r] = mread(r, 0, 32);
         e3n[r] = mread(r, 1, 24);
      end
      chk("wcollide", {33'h0, wc[0]}, {33'h0, cq32});
      chk("wcollide24", {33'h0, wc[3]}, {33'h0, cq24});
      cn32 = mcoll(32);
      cn24 = mcoll(24);
      @(posedge clock);
      if (reset) mclear();
      else begin
         for (int p = 0; p < 2; p++)
            if (we[p])
               for (int l = 0; l < 4; l++)
                  if (wstrb[p][l]) begin
                     mmem[waddr[p]][8*l +: 8] = wdata[p][8*l +: 8];
                     mlw[waddr[p]][l] = 1'b1;
                  end
         for (int r = 0; r < 2; r++) begin
            e2q[r] = e2n[r];
            e3q[r] = e3n[r];
         end
         cq32 = cn32;
         cq24 = cn24;
      end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; re = '0; we = '0; raddr = '0; waddr = '0; wstrb = '0; wdata = '0;
      @(posedge clock);
      mclear();
      @(negedge clock);
      // reset state, then fresh read of entry 3
      re[0] = 1'b1; raddr[0] = 5'd3;
      cyc();
      reset = 1'b0;
      #1 chk("tp_fresh", {rd[0][0], rv[0][0], ru[0][0]}, {32'h0, 2'b11});
      cyc();
      // full write then readback
      re = '0; we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hAABBCCDD; wstrb[0] = 4'hF;
      cyc();
      we = '0; re[0] = 1'b1; raddr[0] = 5'd5;
      #1 chk("tp_full", {rd[0][0], rv[0][0], ru[0][0]}, {32'hAABBCCDD, 2'b10});
      cyc();
      // colliding writes, port 1 wins lanes 0-1
      we = 2'b11; waddr[0] = 5'd2; waddr[1] = 5'd2;
      wdata[0] = 32'h11111111; wstrb[0] = 4'hF; wdata[1] = 32'h22222222; wstrb[1] = 4'h3;
      cyc();
      we = '0; raddr[0] = 5'd2;
      #1 chk("tp_prio", {rd[0][0], rv[0][0], ru[0][0]}, {32'h11112222, 2'b10});
      chk("tp_coll", {33'h0, wc[0]}, 34'h1);
      cyc();
      // partial lane writes and runinit
      we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h00000077; wstrb[0] = 4'h1; re = '0;
      cyc();
      we = '0; re[0] = 1'b1; raddr[0] = 5'd9;
      #1 chk("tp_part", {rd[0][0], rv[0][0], ru[0][0]}, {32'h00000077, 2'b11});
      cyc();
      we[0] = 1'b1; wdata[0] = 32'h12345600; wstrb[0] = 4'hE; re = '0;
      cyc();
      we = '0; re[0] = 1'b1;
      #1 chk("tp_fill", {rd[0][0], rv[0][0], ru[0][0]}, {32'h12345677, 2'b10});
      cyc();
      // same-cycle bypass versus pre-write read
      we[0] = 1'b1; waddr[0] = 5'd7; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF; raddr[0] = 5'd7;
      #1 chk("tp_byp", {rd[1][0], rv[1][0], ru[1][0]}, {32'hDEADBEEF, 2'b10});
      chk("tp_nobyp", {rd[0][0], rv[0][0], ru[0][0]}, {32'h0, 2'b11});
      cyc();
      // registered read, then reset overriding the pipeline
      we = '0; raddr[0] = 5'd5;
      cyc();
      reset = 1'b1;
      #1 chk("tp_lat1", {rd[2][0], rv[2][0], ru[2][0]}, {32'hAABBCCDD, 2'b10});
      cyc();
      reset = 1'b0; re = '0;
      #1 chk("tp_lat_rst", {rd[2][0], rv[2][0], ru[2][0]}, 34'h0);
      cyc();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         for (int p = 0; p < 2; p++) begin
            we[p]    = !reset && $urandom_range(0, 1) == 1;
            waddr[p] = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            wstrb[p] = 4'($urandom_range(0, 15));
            wdata[p] = $urandom;
            re[p]    = $urandom_range(0, 3) != 0;
            raddr[p] = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         end
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
